// File: rtl/scancode_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scancode_disp_pkg
// Brief    : Shared constants for the scan-code display: hex segment table,
//            blank pattern and digit count.
// Revision : 1.0 - initial release
// ============================================================================
package scancode_disp_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} patterns for 0..F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_7seg
// Brief    : Combinational nibble to active-low seven-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_7seg
    import scancode_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        seg_o = SEG_HEX[nibble_i];
    end

endmodule
`default_nettype wire

// File: rtl/scancode_display.sv
`default_nettype none
// ============================================================================
// Module   : scancode_display
// Brief    : Synchronizes and debounces a keyboard scan code, keeps the last
//            two accepted codes and multiplexes them onto four 7-seg digits.
// Revision : 1.0 - initial release
// ============================================================================
module scancode_display
    import scancode_disp_pkg::*;
#(
    parameter int REFRESH_DIV   = 100000,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] CODE,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [3:0] AN,
    output logic       NEW_CODE
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] c_stable_last = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [REF_W-1:0] c_ref_last    = REF_W'(REFRESH_DIV - 1);

    logic [7:0]       sync1_q, sync2_q, sync_last_q;
    logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [7:0]       cur_q, cur_d, prev_q, prev_d;
    logic             new_code_q, new_code_d;
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [6:0]       seg_q;
    logic             dp_q;
    logic [3:0]       an_q, an_d;
    logic             w_same, w_accept;
    logic [3:0]       w_nibble;
    logic [6:0]       w_seg;

    // The counter saturates at its last value so a held code is accepted once
    always_comb begin
        w_same     = (sync2_q == sync_last_q);
        stab_cnt_d = stab_cnt_q;
        if (!w_same) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != c_stable_last) begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end
        w_accept = (stab_cnt_d == c_stable_last) &&
                   (!w_same || (stab_cnt_q != c_stable_last));

        cur_d      = cur_q;
        prev_d     = prev_q;
        new_code_d = 1'b0;
        if (w_accept && (sync2_q != cur_q)) begin
            prev_d     = cur_q;
            cur_d      = sync2_q;
            new_code_d = 1'b1;
        end
    end

    always_comb begin
        ref_cnt_d = ref_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (ref_cnt_q == c_ref_last) begin
            ref_cnt_d = '0;
            idx_d     = idx_q + 1'b1;
        end

        case (idx_q)
            2'd0:    w_nibble = cur_q[3:0];
            2'd1:    w_nibble = cur_q[7:4];
            2'd2:    w_nibble = prev_q[3:0];
            default: w_nibble = prev_q[7:4];
        endcase

        an_d = ~(4'b0001 << idx_q);
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble_i (w_nibble),
        .seg_o    (w_seg)
    );

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync_last_q <= '0;
            stab_cnt_q  <= '0;
            cur_q       <= '0;
            prev_q      <= '0;
            new_code_q  <= 1'b0;
            ref_cnt_q   <= '0;
            idx_q       <= '0;
            seg_q       <= SEG_HEX[0];
            dp_q        <= 1'b1;
            an_q        <= 4'b1110;
        end else begin
            sync1_q     <= CODE;
            sync2_q     <= sync1_q;
            sync_last_q <= sync2_q;
            stab_cnt_q  <= stab_cnt_d;
            cur_q       <= cur_d;
            prev_q      <= prev_d;
            new_code_q  <= new_code_d;
            ref_cnt_q   <= ref_cnt_d;
            idx_q       <= idx_d;
            seg_q       <= w_seg;
            dp_q        <= (idx_q != 2'd2);
            an_q        <= an_d;
        end
    end

    assign SEG      = seg_q;
    assign DP       = dp_q;
    assign AN       = an_q;
    assign NEW_CODE = new_code_q;

endmodule
`default_nettype wire

// File: doc/scancode_display.md
SCANCODE_DISPLAY -- requirements
Module: scancode_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, sets CLK cycles per display digit slot (1 kHz digit rate at 100 MHz).
REQ-002 Parameter STABLE_CYCLES, default 4, sets the consecutive equal synchronized samples required to accept a code.
REQ-003 CLK  input  1  system clock; every flop is clocked on its rising edge.
REQ-004 RESETN  input  1  reset; synchronous to CLK, active-low.
REQ-005 CODE  input  8  scan code from the keyboard receiver; asynchronous to CLK.
REQ-006 SEG  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-007 DP  output  1  decimal point, active-low.
REQ-008 AN  output  4  digit enables, one-hot active-low; AN[0] is the rightmost digit.
REQ-009 NEW_CODE  output  1  one-cycle pulse when a new code is accepted.

Function
REQ-010 CODE shall pass through a two-flop synchronizer, giving SYNC[7:0].
REQ-011 A stability counter shall increment while SYNC equals its previous-cycle value and restart at 0 on any change.
REQ-012 A code shall be accepted in the cycle the counter reaches STABLE_CYCLES-1 and shall not be re-accepted until SYNC changes.
REQ-013 On acceptance with SYNC != CUR: PREV<=CUR, CUR<=SYNC, NEW_CODE=1 for exactly that cycle.
REQ-014 On acceptance with SYNC == CUR: no register update and NEW_CODE stays 0.
REQ-015 Refresh counter shall count 0..REFRESH_DIV-1 and wrap to 0; on wrap, digit index (2 bits) shall increment, wrapping 3->0.
REQ-016 Digit mapping: index0=CUR[3:0], index1=CUR[7:4], index2=PREV[3:0], index3=PREV[7:4].
REQ-017 Nibble decode, active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-018 DP shall be 0 only when index=2 (separator between codes), else 1.
REQ-019 SEG, DP and AN shall be registered; they reflect a new index, or a CUR/PREV update, one cycle later.
REQ-020 A CUR/PREV update shall take effect on the next refresh of the affected digit without disturbing the refresh sequence.
REQ-021 End-to-end latency from a stable CODE change to NEW_CODE shall be 2 + STABLE_CYCLES cycles, with no variation.

Reset
REQ-022 While RESETN=0 at a CLK edge: CUR=PREV=8'h00, counters=0, index=0, NEW_CODE=0.
REQ-023 After that reset edge, AN=4'b1110, SEG=7'b1000000, DP=1.
REQ-024 Reset asserted mid-filter or mid-refresh shall discard all partial state, and the synchronizer flops shall clear to 0.
REQ-025 The first acceptance after reset shall compare SYNC against CUR=00, so CODE=00 yields no NEW_CODE.

Structure
REQ-026 A shared package scancode_disp_pkg shall hold the 16-entry segment table constants, SEG_BLANK=7'b1111111 and NUM_DIGITS=4.
REQ-027 Nibble-to-segment decode shall be a combinational sub-module hex_to_7seg (4-bit in, 7-bit active-low out).
REQ-028 The synchronizer, stability filter, history registers and refresh/mux logic shall reside in scancode_display.

Verification
REQ-029 Reset: hold RESETN=0 three cycles, release -> AN=1110, SEG=1000000, DP=1, NEW_CODE=0.
REQ-030 Accept: CODE 00->1C held, STABLE_CYCLES=4 -> one NEW_CODE pulse 6 cycles after the change; CUR=1C, PREV=00; index0 SEG=1000110, index1 SEG=1111001.
REQ-031 History: CODE 1C then 32 (each stable) -> CUR=32, PREV=1C; index3 SEG=1111001, index2 SEG=1000110 with DP=0.
REQ-032 Glitch: CODE toggles 1C/33 every 2 cycles for 40 cycles -> NEW_CODE stays 0, CUR unchanged.
REQ-033 Refresh: REFRESH_DIV=5 -> AN sequence 1110,1101,1011,0111,1110 with each digit held 5 cycles.
REQ-034 Reset mid-operation: RESETN=0 at filter count 2 with CUR=1C -> CUR=00, no NEW_CODE; a later stable 1C -> a fresh pulse.
